sram_channel_reader: RTL and testbench

- Per-output read client for the shared `sram_bus`; one instance per output channel, driving that channel's `read_requests[n]` bit and `read_address_n`.
- On a `start` strobe it fetches `word_count` consecutive words beginning at `base_address`, one bus transaction at a time.
- Fetched words go into a small first-word-fall-through FIFO, drained by the downstream channel shifter over a valid/ready handshake.

---
 rtl/sram_channel_reader.sv | 173 +++++++++++++++++
 tb/tb_sram_channel_reader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_channel_reader.sv
// sram_channel_reader: per-output read client for the shared sram_bus.
// On an accepted start it fetches word_count consecutive words from base_address, one bus
// transaction at a time, into a small first-word-fall-through FIFO. The channel shifter drains
// the FIFO over a valid/ready handshake.
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   start                  one-cycle strobe, ignored while busy
//   base_address           first word address, sampled on an accepted start
//   word_count             words to fetch, sampled on an accepted start
//   read_request           to sram_bus read_requests[n]
//   read_address           to sram_bus read_address_n
//   read_finished_strobe   from sram_bus read_finished_strobes[n]
//   read_data              shared sram_bus read data, valid in the strobe cycle only
//   out_data/out_valid     FIFO head word / FIFO non-empty
//   out_ready              consumer takes the head when out_valid & out_ready
//   busy                   run in progress
//   done                   one-cycle strobe at end of run
module sram_channel_reader #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 12,
  parameter int unsigned DATA_BUS_WIDTH    = 16,
  parameter int unsigned COUNT_WIDTH       = 12,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  input  logic [COUNT_WIDTH-1:0]       word_count,
  output logic                         read_request,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic                         read_finished_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic [DATA_BUS_WIDTH-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned PtrWidth = $clog2(FIFO_DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StWait   = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  localparam logic [PtrWidth:0]          FifoFull = FIFO_DEPTH[PtrWidth:0];
  localparam logic [PtrWidth:0]          CntOne   = (PtrWidth + 1)'(1);
  localparam logic [PtrWidth-1:0]        PtrOne   = PtrWidth'(1);
  localparam logic [COUNT_WIDTH-1:0]     RemOne   = COUNT_WIDTH'(1);
  localparam logic [ADDRESS_BUS_WIDTH-1:0] AddrOne = ADDRESS_BUS_WIDTH'(1);

  logic [2:0]                   state_q, state_d;
  logic [ADDRESS_BUS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_BUS_WIDTH-1:0] raddr_q, raddr_d;
  logic [COUNT_WIDTH-1:0]       remaining_q, remaining_d;
  logic                         req_q, req_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [DATA_BUS_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrWidth-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrWidth:0]         fifo_count_q, fifo_count_d;
  logic                      push, pop;

  // Only a strobe answering our own outstanding read is accepted.
  assign push = (state_q == StWait) && read_finished_strobe;
  assign pop  = out_ready && (fifo_count_q != '0);

  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + CntOne;
    end else if (!push && pop) begin
      fifo_count_d = fifo_count_q - CntOne;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    req_d       = req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_address;
          remaining_d = word_count;
          busy_d      = 1'b1;
          state_d     = (word_count == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        // One read in flight at most, so room for one word is enough.
        if (fifo_count_q < FifoFull) begin
          req_d   = 1'b1;
          raddr_d = addr_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (read_finished_strobe) begin
          req_d       = 1'b0;
          addr_d      = addr_q + AddrOne;
          remaining_d = remaining_q - RemOne;
          state_d     = (remaining_q == RemOne) ? StDrain : StIssue;
        end
      end
      StDrain: begin
        if (fifo_count_d == '0) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      raddr_q      <= '0;
      remaining_q  <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      raddr_q      <= raddr_d;
      remaining_q  <= remaining_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fifo_count_q <= fifo_count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr_q] <= read_data;
    end
  end

  // Drop the request in the strobe cycle so the bus cannot re-sample a stale request.
  assign read_request = req_q && !read_finished_strobe;
  assign read_address = raddr_q;
  assign out_valid    = (fifo_count_q != '0);
  assign out_data     = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sram_channel_reader.sv
module tb_sram_channel_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_address;
  logic [11:0] word_count;
  logic        read_request;
  logic [11:0] read_address;
  logic        read_finished_strobe;
  logic [15:0] read_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  sram_channel_reader #(
    .ADDRESS_BUS_WIDTH(12),
    .DATA_BUS_WIDTH   (16),
    .COUNT_WIDTH      (12),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .base_address        (base_address),
    .word_count          (word_count),
    .read_request        (read_request),
    .read_address        (read_address),
    .read_finished_strobe(read_finished_strobe),
    .read_data           (read_data),
    .out_data            (out_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Bus / scoreboard state
  int          reads        = 0;
  int          pop_idx      = 0;
  int          done_cnt     = 0;
  int          valid_cycles = 0;
  int          occ          = 0;
  int          latency      = 0;
  int          bst          = 0;
  int          lat_cnt      = 0;
  logic [11:0] run_base     = '0;
  logic [11:0] cur_addr     = '0;
  logic [11:0] addr_log[$];
  bit          inject       = 1'b0;
  logic [15:0] inject_data  = '0;

  typedef struct {
    logic [11:0] base;
    logic [11:0] count;
    int          lat;
    int          exp_reads;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [11:0] a);
    return (a == 12'h010) ? 16'hBEEF : {4'h0, a};
  endfunction

  // Bus model, consumer scoreboard and FIFO occupancy tracking, all at negedge.
  initial begin
    read_finished_strobe = 1'b0;
    read_data            = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        read_finished_strobe = 1'b0;
        bst = 0;
        occ = 0;
      end else begin
        if (out_valid) valid_cycles++;
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
          chk("pop_data", out_data, mem(run_base + 12'(pop_idx)));
          pop_idx++;
          occ--;
        end
        case (bst)
          0: begin
            if (inject) begin
              read_finished_strobe = 1'b1;
              read_data            = inject_data;
              inject               = 1'b0;
              bst                  = 2;
            end else if (read_request) begin
              cur_addr = read_address;
              addr_log.push_back(read_address);
              reads++;
              lat_cnt = latency;
              bst     = 1;
            end
          end
          1: begin
            chk("addr_stable", read_address, cur_addr);
            if (lat_cnt == 0) begin
              read_finished_strobe = 1'b1;
              read_data            = mem(cur_addr);
              occ++;
              chk("fifo_no_overflow", (occ <= 4), 1);
              bst = 2;
            end else begin
              lat_cnt--;
            end
          end
          default: begin
            // Bus is idle again right after the strobe edge and re-samples the request.
            read_finished_strobe = 1'b0;
            chk("no_dup_request", read_request, 1'b0);
            bst = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_run(input logic [11:0] b);
    reads        = 0;
    pop_idx      = 0;
    done_cnt     = 0;
    valid_cycles = 0;
    run_base     = b;
    addr_log.delete();
  endtask

  task automatic pulse_start(input logic [11:0] b, input logic [11:0] n);
    @(posedge clk) #1;
    start        = 1'b1;
    base_address = b;
    word_count   = n;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      if (done_cnt != 0) break;
    end
    chk(name, (done_cnt != 0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read_request"}, read_request, 1'b0);
    chk({tag, "_read_address"}, read_address, 12'h000);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 16'h0000);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    vecs[0] = '{base: 12'h010, count: 12'd1, lat: 1, exp_reads: 1,
                exp_first: 12'h010, exp_last: 12'h010};
    vecs[1] = '{base: 12'h020, count: 12'd3, lat: 0, exp_reads: 3,
                exp_first: 12'h020, exp_last: 12'h022};
    vecs[2] = '{base: 12'hFFE, count: 12'd4, lat: 2, exp_reads: 4,
                exp_first: 12'hFFE, exp_last: 12'h001};
    vecs[3] = '{base: 12'h200, count: 12'd8, lat: 1, exp_reads: 8,
                exp_first: 12'h200, exp_last: 12'h207};

    rst          = 1'b1;
    start        = 1'b0;
    base_address = '0;
    word_count   = '0;
    out_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk) #1;
    rst = 1'b0;

    // Table-driven runs with the consumer always ready
    for (int v = 0; v < 4; v++) begin
      latency   = vecs[v].lat;
      out_ready = 1'b1;
      clear_run(vecs[v].base);
      pulse_start(vecs[v].base, vecs[v].count);
      wait_done($sformatf("v%0d_done_seen", v), 300);
      repeat (4) @(posedge clk);
      chk($sformatf("v%0d_reads", v), reads, vecs[v].exp_reads);
      chk($sformatf("v%0d_pops", v), pop_idx, vecs[v].exp_reads);
      chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
      chk($sformatf("v%0d_valid_cycles", v), valid_cycles, vecs[v].exp_reads);
      chk($sformatf("v%0d_busy_after", v), busy, 1'b0);
      if (addr_log.size() != 0) begin
        chk($sformatf("v%0d_first_addr", v), addr_log[0], vecs[v].exp_first);
        chk($sformatf("v%0d_last_addr", v), addr_log[addr_log.size() - 1], vecs[v].exp_last);
      end
      for (int k = 0; k < addr_log.size(); k++) begin
        logic [11:0] ea;
        ea = vecs[v].base + 12'(k);
        chk($sformatf("v%0d_addr%0d", v, k), addr_log[k], ea);
      end
    end

    // Burst with a stalled consumer: only FIFO_DEPTH reads may go out
    latency   = 0;
    out_ready = 1'b0;
    clear_run(12'h100);
    pulse_start(12'h100, 12'd6);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("stall_reads", reads, 4);
    chk("stall_read_request", read_request, 1'b0);
    chk("stall_out_valid", out_valid, 1'b1);
    chk("stall_head", out_data, 16'h0100);
    chk("stall_busy", busy, 1'b1);
    chk("stall_no_done", done_cnt, 0);
    @(posedge clk) #1;
    out_ready = 1'b1;
    wait_done("stall_done_seen", 300);
    repeat (4) @(posedge clk);
    chk("stall_total_reads", reads, 6);
    chk("stall_pops", pop_idx, 6);
    chk("stall_done_pulses", done_cnt, 1);
    chk("stall_last_addr", addr_log[addr_log.size() - 1], 12'h105);

    // count = 0: no request, done two cycles after start
    clear_run(12'h050);
    @(posedge clk) #1;
    start        = 1'b1;
    base_address = 12'h050;
    word_count   = 12'd0;
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_busy_c1", busy, 1'b1);
    chk("zero_done_c1", done, 1'b0);
    @(negedge clk);
    chk("zero_done_c2", done, 1'b1);
    chk("zero_busy_c2", busy, 1'b0);
    @(negedge clk);
    chk("zero_done_c3", done, 1'b0);
    repeat (3) @(posedge clk);
    chk("zero_reads", reads, 0);

    // Second start mid-run is ignored
    latency = 2;
    clear_run(12'h300);
    pulse_start(12'h300, 12'd3);
    repeat (2) @(posedge clk);
    pulse_start(12'h500, 12'd5);
    wait_done("restart_done_seen", 300);
    repeat (12) @(posedge clk);
    chk("restart_reads", reads, 3);
    chk("restart_pops", pop_idx, 3);
    chk("restart_done_pulses", done_cnt, 1);
    chk("restart_last_addr", addr_log[addr_log.size() - 1], 12'h302);

    // Reset in WAIT with two words buffered, then a late strobe
    latency   = 10;
    out_ready = 1'b0;
    clear_run(12'h400);
    pulse_start(12'h400, 12'd6);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (reads >= 3) break;
    end
    chk("midrst_third_read_issued", reads, 3);
    @(negedge clk);
    chk("midrst_pre_valid", out_valid, 1'b1);
    chk("midrst_pre_request", read_request, 1'b1);
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    clear_run(12'h000);
    inject_data = 16'h1234;
    inject      = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("late_strobe_valid%0d", i), out_valid, 1'b0);
      chk($sformatf("late_strobe_busy%0d", i), busy, 1'b0);
    end
    chk("late_strobe_reads", reads, 0);

    // start in the same cycle as reset: reset wins
    latency = 0;
    @(posedge clk) #1;
    rst          = 1'b1;
    start        = 1'b1;
    base_address = 12'h600;
    word_count   = 12'd2;
    @(posedge clk) #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    chk("rst_start_reads", reads, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
